seq_magnitude_comparator: RTL and testbench

- Iterative magnitude comparator for WIDTH-bit operands, processed MSB-first, one SLICE-bit slice per clock.
- Terminates early at the first unequal slice.
- valid/ready handshake on both input and result sides, so it can sit behind a register stage or arbiter where a wide single-cycle compare would fail timing.
- Generalises the fixed 16-bit / 4x4-bit combinational comparator to any width and slice size.

---
 rtl/cmp_pkg.sv | 17 +
 rtl/cmp_slice.sv | 24 ++
 rtl/seq_magnitude_comparator.sv | 140 ++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the iterative magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // One-hot slice-compare result, packed as {gt, lt, eq}.
  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t RES_GT = 3'b100;
  localparam cmp_res_t RES_LT = 3'b010;
  localparam cmp_res_t RES_EQ = 3'b001;

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one SLICE-bit slice pair; exactly one output is high.
module cmp_slice
  import cmp_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  cmp_res_t res;

  always_comb begin
    res = RES_EQ;
    if (x > y)      res = RES_GT;
    else if (x < y) res = RES_LT;
  end

  assign {gt, lt, eq} = res;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// MSB-first iterative magnitude comparator, one SLICE-bit slice per clock, with early exit.
// Optional macro CMP_SIGNED_EN adds an is_signed input for two's-complement compares.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  localparam int NSLICE = WIDTH / SLICE,
  localparam int CW     = $clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             agb,
  output logic             asb,
  output logic             aeb,
  output logic [CW-1:0]    out_slices
);

  if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("seq_magnitude_comparator: WIDTH must be a positive multiple of SLICE");
  end

  cmp_state_t       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             top_gt;
  logic             top_lt;
  logic             top_eq;

`ifdef CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement onto offset binary, so the
  // unsigned slice compare then orders signed values correctly.
  logic [WIDTH-1:0] msb_flip;

  always_comb begin
    msb_flip            = '0;
    msb_flip[WIDTH-1]   = is_signed;
  end

  assign cap_a = a ^ msb_flip;
  assign cap_b = b ^ msb_flip;
`else
  assign cap_a = a;
  assign cap_b = b;
`endif

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .x  (sa[WIDTH-1 -: SLICE]),
    .y  (sb[WIDTH-1 -: SLICE]),
    .gt (top_gt),
    .lt (top_lt),
    .eq (top_eq)
  );

  // NOTE: every register here, outputs included, uses non-blocking assignments
  // so all state updates see the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      agb        <= 1'b0;
      asb        <= 1'b0;
      aeb        <= 1'b0;
      out_slices <= '0;
      sa         <= '0;
      sb         <= '0;
      idx        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa       <= cap_a;
            sb       <= cap_b;
            idx      <= CW'(NSLICE - 1);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          cnt <= cnt + CW'(1);
          if (!top_eq) begin
            agb        <= top_gt;
            asb        <= top_lt;
            aeb        <= 1'b0;
            out_slices <= cnt + CW'(1);
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (idx == '0) begin
            agb        <= 1'b0;
            asb        <= 1'b0;
            aeb        <= 1'b1;
            out_slices <= CW'(NSLICE);
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            sa  <= sa << SLICE;
            sb  <= sb << SLICE;
            idx <= idx - CW'(1);
          end
        end

        DONE: begin
          // in_valid is deliberately ignored here; new operands wait for IDLE.
          if (out_ready) begin
            out_valid  <= 1'b0;
            agb        <= 1'b0;
            asb        <= 1'b0;
            aeb        <= 1'b0;
            out_slices <= '0;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed-vector bench for seq_magnitude_comparator (WIDTH=16, SLICE=4).
// Signed-mode vectors run only when CMP_SIGNED_EN is defined.
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              is_signed = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              agb, asb, aeb;
  logic [CW-1:0]     out_slices;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
`ifdef CMP_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .agb        (agb),
    .asb        (asb),
    .aeb        (aeb),
    .out_slices (out_slices)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one operand pair for exactly one accepting edge.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic sg);
    @(negedge clk);
    a = va; b = vb; is_signed = sg; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count rising edges from the accept edge until out_valid; 0 means timed out.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Consume the pending result and confirm the block returns to IDLE cleanly.
  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s consume out_valid: got %b want 0", tag, out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s consume in_ready: got %b want 1", tag, in_ready); end
    n_cmp++; if ({agb, asb, aeb} !== 3'b000) begin n_bad++; $display("FAIL %s consume flags: got %b want 000", tag, {agb, asb, aeb}); end
  endtask

  // One full transaction with expected latency, flags {agb,asb,aeb} and slice count.
  task automatic run_vector(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic sg, input int exp_lat, input logic [2:0] exp_flags,
                            input logic [CW-1:0] exp_slices);
    int lat;
    send(va, vb, sg);
    wait_result(lat);
    n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
    n_cmp++; if ({agb, asb, aeb} !== exp_flags) begin n_bad++; $display("FAIL %s flags: got %b want %b", tag, {agb, asb, aeb}, exp_flags); end
    n_cmp++; if (out_slices !== exp_slices) begin n_bad++; $display("FAIL %s out_slices: got %0d want %0d", tag, out_slices, exp_slices); end
    consume(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({agb, asb, aeb} !== 3'b000) begin n_bad++; $display("FAIL reset flags: got %b want 000", {agb, asb, aeb}); end
    n_cmp++; if (out_slices !== 3'd0) begin n_bad++; $display("FAIL reset out_slices: got %0d want 0", out_slices); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_compare();
    run_vector("first_slice_gt", 16'hA000, 16'h9FFF, 1'b0, 1, 3'b100, 3'd1);
    run_vector("equal",          16'h1234, 16'h1234, 1'b0, 4, 3'b001, 3'd4);
    run_vector("last_slice_lt",  16'h1233, 16'h1234, 1'b0, 4, 3'b010, 3'd4);
    run_vector("third_slice_gt", 16'h12F4, 16'h1234, 1'b0, 3, 3'b100, 3'd3);
    run_vector("zero_equal",     16'h0000, 16'h0000, 1'b0, 4, 3'b001, 3'd4);
    run_vector("max_vs_zero",    16'hFFFF, 16'h0000, 1'b0, 1, 3'b100, 3'd1);
  endtask

  task automatic test_backpressure();
    int lat;
    send(16'h00F0, 16'h0F00, 1'b0);
    wait_result(lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL bp latency: got %0d want 2", lat); end
    // Offer a new pair while the result is stalled; it must not be taken.
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp hold out_valid cycle %0d: got %b want 1", i, out_valid); end
      n_cmp++; if ({agb, asb, aeb} !== 3'b010) begin n_bad++; $display("FAIL bp hold flags cycle %0d: got %b want 010", i, {agb, asb, aeb}); end
      n_cmp++; if (out_slices !== 3'd2) begin n_bad++; $display("FAIL bp hold out_slices cycle %0d: got %0d want 2", i, out_slices); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp hold in_ready cycle %0d: got %b want 0", i, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp release out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    // in_valid is still high, so the pending pair is accepted at this edge.
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp accept in_ready: got %b want 0", in_ready); end
    wait_result(lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL bp second latency: got %0d want 4", lat); end
    n_cmp++; if ({agb, asb, aeb} !== 3'b001) begin n_bad++; $display("FAIL bp second flags: got %b want 001", {agb, asb, aeb}); end
    n_cmp++; if (out_slices !== 3'd4) begin n_bad++; $display("FAIL bp second out_slices: got %0d want 4", out_slices); end
    consume("bp_second");
  endtask

  task automatic test_reset_mid_run();
    int seen;
    send(16'h1111, 16'h1112, 1'b0);
    // First RUN edge has passed; assert reset part-way through the second RUN cycle.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({agb, asb, aeb} !== 3'b000) begin n_bad++; $display("FAIL midrst flags: got %b want 000", {agb, asb, aeb}); end
    n_cmp++; if (out_slices !== 3'd0) begin n_bad++; $display("FAIL midrst out_slices: got %0d want 0", out_slices); end
    #4 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst stray out_valid cycles: got %0d want 0", seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst in_ready: got %b want 1", in_ready); end
    run_vector("after_reset", 16'h1111, 16'h1112, 1'b0, 4, 3'b010, 3'd4);
  endtask

`ifdef CMP_SIGNED_EN
  task automatic test_signed();
    run_vector("signed_neg_lt",   16'h8000, 16'h0001, 1'b1, 1, 3'b010, 3'd1);
    run_vector("unsigned_big_gt", 16'h8000, 16'h0001, 1'b0, 1, 3'b100, 3'd1);
    run_vector("signed_m1_vs_m2", 16'hFFFF, 16'hFFFE, 1'b1, 4, 3'b100, 3'd4);
  endtask
`endif

  initial begin
    test_reset();
    test_compare();
    test_backpressure();
    test_reset_mid_run();
`ifdef CMP_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
